dpmu_dvfs_seq: RTL and testbench
================================

Name: dpmu_dvfs_seq

Overview:
Parametrised successor to the single-FSM DPMU. It drives NUM_DOM voltage/frequency domains instead of fixed core1/core2/mem fields. Adds dwell-time hysteresis on mode changes, per-domain idle gating, and safe V/F ramp sequencing with settle delays. It sits between the sensor/request inputs and the pad-level V/F control outputs.

Parameters:
NUM_DOM, 3, number of independent V/F domains
VW, 2, voltage-level width per domain (VMAX = 2^VW-1, VMID = 2^(VW-1))
FW, 3, frequency-level width per domain (FMAX = 2^FW-1, FMID = 2^(FW-1))
SETTLE_CYC, 4, hold cycles after every single-LSB V or F step (>=1)
DWELL_CYC, 8, consecutive cycles a non-emergency candidate mode must persist before commit (>=1)

Ports:
clk  input  1  system clock
rst  input  1  reset; asynchronous, active-high
perf_req  input  1  performance request
temp_level  input  2  temperature; >=2 is hot
batt_level  input  2  battery; <2 is low
dom_busy  input  NUM_DOM  per-domain workload active
vlevel  output  NUM_DOM*VW  per-domain voltage level; domain d occupies [d*VW +: VW]
flevel  output  NUM_DOM*FW  per-domain frequency level; domain d occupies [d*FW +: FW]
mode  output  3  committed mode: 0 NORMAL, 1 PERF, 2 POWERSAVE, 3 THERMAL, 4 BATTERY
power_save  output  1  high when mode is POWERSAVE or BATTERY
transition_busy  output  1  high while any domain is off target or settling

Behaviour:
- Reset (async, rst=1): mode=NORMAL; all vlevel/flevel=0; candidate=NORMAL; dwell counter=0; all settle counters=0; power_save=0; transition_busy=0.
- After reset release, domains ramp from 0 to their NORMAL targets under the sequencing rules below.
- Candidate mode is combinational, highest priority first:
  - BATTERY if batt_level<2
  - THERMAL if temp_level>=2
  - PERF if perf_req
  - POWERSAVE if dom_busy==0
  - otherwise NORMAL
- Emergency commit: BATTERY or THERMAL candidate that ranks higher than the current mode commits at the next edge, with no dwell.
- Dwell commit (all other changes):
  - Candidate==mode clears the dwell counter.
  - A candidate different from the previous cycle's candidate reloads the counter to 1.
  - Otherwise the counter increments.
  - Mode takes the candidate on the edge where the counter reaches DWELL_CYC; the counter is then cleared.
- Mode targets (V,F), applied to every domain:
  - PERF: (VMAX, FMAX)
  - NORMAL: (VMID, FMID)
  - THERMAL: (VMID, FMID-1)
  - POWERSAVE: (1, 1)
  - BATTERY: (0, 0)
- Idle gating: in NORMAL or THERMAL, a domain with dom_busy[d]=0 uses the POWERSAVE target (1,1).
- Per-domain sequencer; each edge where settle_cnt==0, take at most one step:
  - if F>Ftgt, F-1;
  - else if V!=Vtgt, V±1;
  - else if F<Ftgt, F+1.
  - Any step loads settle_cnt=SETTLE_CYC.
  - settle_cnt decrements to 0 on following edges.
  - Consecutive steps are therefore SETTLE_CYC+1 cycles apart.
  - This ordering guarantees voltage rises before frequency and frequency falls before voltage.
- Target changes mid-ramp: the next step uses the current target, so the ramp may reverse. No step is aborted; the settle delay is always honoured.
- Targets are always in range, so no arithmetic wrap is possible.
- transition_busy = OR over domains of (V!=Vtgt or F!=Ftgt or settle_cnt!=0). It is registered-state derived and has no combinational path from inputs other than via targets.
- Reset mid-ramp: all levels return to 0 immediately (async).

Optional Feature:
DPMU_TRANS_CNT_EN
- Defined: adds output port trans_cnt [7:0]. It increments on every committed mode change (emergency or dwell), saturates at 255, and resets to 0.
- Undefined: the port and the counter are absent; all other behaviour is identical.

Test Plan:
- Reset, then release with batt=3, temp=0, perf=0, busy=111 -> steps at edges 1,6,11,16,21,26 (V 0→1→2, then F 0→4); final V=2, F=4 per domain; transition_busy low from edge 30; mode=0.
- Settled NORMAL, perf_req=1 held -> mode=1 on the 8th edge; V 2→3 first, then F 4→5→6→7; perf_req pulse of 5 cycles -> mode stays 0, no steps.
- Settled NORMAL, temp=2 -> mode=3 at the next edge (no dwell); F 4→3 only, V stays 2; temp back to 0 -> mode=0 after 8 cycles; F 3→4.
- Settled NORMAL, busy=101 -> domain1 F 4→3→2→1, then V 2→1; domains 0 and 2 unchanged; mode stays 0.
- During the PERF ramp (V=3, F=5), batt=1 -> mode=4 next edge, power_save=1; all domains F 5→0 first, then V 3→0; transition_busy low after the final settle.
- With DPMU_TRANS_CNT_EN: 300 alternating THERMAL entries/exits -> trans_cnt saturates at 255; async rst -> 0.

Source files
------------

// File: rtl/dpmu_dvfs_seq.sv
// Multi-domain DVFS sequencer: dwell-filtered mode selection, idle gating and ordered V/F ramps.
// Optional `DPMU_TRANS_CNT_EN adds a saturating committed-mode-change counter output (trans_cnt).
module dpmu_dvfs_seq #(
    parameter int NUM_DOM    = 3,
    parameter int VW         = 2,
    parameter int FW         = 3,
    parameter int SETTLE_CYC = 4,
    parameter int DWELL_CYC  = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  perf_req,
    input  logic [1:0]            temp_level,
    input  logic [1:0]            batt_level,
    input  logic [NUM_DOM-1:0]    dom_busy,
    output logic [NUM_DOM*VW-1:0] vlevel,
    output logic [NUM_DOM*FW-1:0] flevel,
    output logic [2:0]            mode,
    output logic                  power_save,
`ifdef DPMU_TRANS_CNT_EN
    output logic [7:0]            trans_cnt,
`endif
    output logic                  transition_busy
);
    typedef enum logic [2:0] {
        M_NORMAL = 3'd0,
        M_PERF   = 3'd1,
        M_PSAVE  = 3'd2,
        M_THERM  = 3'd3,
        M_BATT   = 3'd4
    } mode_t;

    localparam int DCW = $clog2(DWELL_CYC + 1);
    localparam int SCW = $clog2(SETTLE_CYC + 1);
    localparam logic [DCW-1:0] DWELL_LIM = DCW'(DWELL_CYC);
    localparam logic [SCW-1:0] SETTLE_LD = SCW'(SETTLE_CYC);
    localparam logic [VW-1:0]  VMAX = {VW{1'b1}};
    localparam logic [VW-1:0]  VMID = VW'(1 << (VW - 1));
    localparam logic [FW-1:0]  FMAX = {FW{1'b1}};
    localparam logic [FW-1:0]  FMID = FW'(1 << (FW - 1));

    // Priority rank used to decide whether an emergency candidate outranks the current mode.
    function automatic logic [2:0] f_rank(input mode_t m);
        case (m)
            M_BATT:  f_rank = 3'd4;
            M_THERM: f_rank = 3'd3;
            M_PERF:  f_rank = 3'd2;
            M_PSAVE: f_rank = 3'd1;
            default: f_rank = 3'd0;
        endcase
    endfunction

    mode_t          r_mode;
    mode_t          r_cand;
    mode_t          w_cand;
    logic [DCW-1:0] r_dwell;
    logic [DCW-1:0] w_dwell_nxt;
    logic           r_power_save;
    logic           r_trans_busy;
    logic           w_emerg;
    logic           w_commit;
    logic [NUM_DOM-1:0] w_pend;

    always_comb begin
        w_cand = M_NORMAL;
        if (batt_level < 2'd2)       w_cand = M_BATT;
        else if (temp_level >= 2'd2) w_cand = M_THERM;
        else if (perf_req)           w_cand = M_PERF;
        else if (dom_busy == '0)     w_cand = M_PSAVE;
    end

    assign w_dwell_nxt = (w_cand != r_cand) ? DCW'(1) : r_dwell + DCW'(1);
    assign w_emerg     = ((w_cand == M_BATT) || (w_cand == M_THERM)) &&
                         (f_rank(w_cand) > f_rank(r_mode));
    assign w_commit    = w_emerg || ((w_cand != r_mode) && (w_dwell_nxt == DWELL_LIM));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mode       <= M_NORMAL;
            r_cand       <= M_NORMAL;
            r_dwell      <= '0;
            r_power_save <= 1'b0;
        end else begin
            r_cand <= w_cand;
            if (w_commit) begin
                r_mode       <= w_cand;
                r_dwell      <= '0;
                r_power_save <= (w_cand == M_PSAVE) || (w_cand == M_BATT);
            end else if (w_cand == r_mode) begin
                r_dwell <= '0;
            end else begin
                r_dwell <= w_dwell_nxt;
            end
        end
    end

`ifdef DPMU_TRANS_CNT_EN
    logic [7:0] r_trans_cnt;
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_trans_cnt <= '0;
        else if (w_commit && (r_trans_cnt != 8'hFF))
            r_trans_cnt <= r_trans_cnt + 8'd1;
    end
    assign trans_cnt = r_trans_cnt;
`endif

    genvar gi;
    generate
        for (gi = 0; gi < NUM_DOM; gi++) begin : g_dom
            logic [VW-1:0]  r_v;
            logic [FW-1:0]  r_f;
            logic [SCW-1:0] r_settle;
            logic [VW-1:0]  w_vt;
            logic [FW-1:0]  w_ft;
            logic [VW-1:0]  w_v_nxt;
            logic [FW-1:0]  w_f_nxt;
            logic [SCW-1:0] w_settle_nxt;

            always_comb begin
                w_vt = '0;
                w_ft = '0;
                case (r_mode)
                    M_PERF:   begin w_vt = VMAX; w_ft = FMAX;         end
                    M_NORMAL: begin w_vt = VMID; w_ft = FMID;         end
                    M_THERM:  begin w_vt = VMID; w_ft = FMID - FW'(1); end
                    M_PSAVE:  begin w_vt = VW'(1); w_ft = FW'(1);     end
                    default:  begin w_vt = '0;   w_ft = '0;           end
                endcase
                if (((r_mode == M_NORMAL) || (r_mode == M_THERM)) && !dom_busy[gi]) begin
                    w_vt = VW'(1);
                    w_ft = FW'(1);
                end
            end

            // Frequency drops before voltage moves; voltage settles before frequency rises.
            always_comb begin
                w_v_nxt      = r_v;
                w_f_nxt      = r_f;
                w_settle_nxt = r_settle;
                if (r_settle != '0) begin
                    w_settle_nxt = r_settle - SCW'(1);
                end else if (r_f > w_ft) begin
                    w_f_nxt      = r_f - FW'(1);
                    w_settle_nxt = SETTLE_LD;
                end else if (r_v < w_vt) begin
                    w_v_nxt      = r_v + VW'(1);
                    w_settle_nxt = SETTLE_LD;
                end else if (r_v > w_vt) begin
                    w_v_nxt      = r_v - VW'(1);
                    w_settle_nxt = SETTLE_LD;
                end else if (r_f < w_ft) begin
                    w_f_nxt      = r_f + FW'(1);
                    w_settle_nxt = SETTLE_LD;
                end
            end

            assign w_pend[gi] = (w_v_nxt != w_vt) || (w_f_nxt != w_ft) || (w_settle_nxt != '0);

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_v      <= '0;
                    r_f      <= '0;
                    r_settle <= '0;
                end else begin
                    r_v      <= w_v_nxt;
                    r_f      <= w_f_nxt;
                    r_settle <= w_settle_nxt;
                end
            end

            assign vlevel[gi*VW +: VW] = r_v;
            assign flevel[gi*FW +: FW] = r_f;
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_trans_busy <= 1'b0;
        else     r_trans_busy <= |w_pend;
    end

    assign mode            = r_mode;
    assign power_save      = r_power_save;
    assign transition_busy = r_trans_busy;
endmodule

// File: tb/tb_dpmu_dvfs_seq.sv
// Bench for dpmu_dvfs_seq: directed table, corner-case sequences and random stimulus against a model.
module tb_dpmu_dvfs_seq;
    localparam int ND = 3, VW = 2, FW = 3, SETTLE = 4, DWELL = 8;
    localparam int VMAX = (1 << VW) - 1, VMID = 1 << (VW - 1);
    localparam int FMAX = (1 << FW) - 1, FMID = 1 << (FW - 1);

    logic clk = 1'b0, rst = 1'b1, perf_req = 1'b0;
    logic [1:0] temp_level = 2'd0, batt_level = 2'd3;
    logic [ND-1:0] dom_busy = 3'b111;
    logic [ND*VW-1:0] vlevel;
    logic [ND*FW-1:0] flevel;
    logic [2:0] mode;
    logic power_save, transition_busy;
`ifdef DPMU_TRANS_CNT_EN
    logic [7:0] trans_cnt;
`endif

    dpmu_dvfs_seq dut (
        .clk(clk), .rst(rst), .perf_req(perf_req), .temp_level(temp_level),
        .batt_level(batt_level), .dom_busy(dom_busy), .vlevel(vlevel), .flevel(flevel),
        .mode(mode), .power_save(power_save),
`ifdef DPMU_TRANS_CNT_EN
        .trans_cnt(trans_cnt),
`endif
        .transition_busy(transition_busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0, n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: mode codes 0 NORMAL,1 PERF,2 PSAVE,3 THERM,4 BATT
    int mv[ND], mf[ND], ms[ND];
    int m_mode, m_prev, m_dwell, m_cnt, m_tb;

    function automatic int rank(input int m);
        case (m)
            4: return 4;
            3: return 3;
            1: return 2;
            2: return 1;
            default: return 0;
        endcase
    endfunction

    task automatic model_reset();
        for (int d = 0; d < ND; d++) begin mv[d] = 0; mf[d] = 0; ms[d] = 0; end
        m_mode = 0; m_prev = 0; m_dwell = 0; m_cnt = 0; m_tb = 0;
    endtask

    task automatic model_edge();
        int vt, ft, c, any;
        any = 0;
        for (int d = 0; d < ND; d++) begin
            case (m_mode)
                1: begin vt = VMAX; ft = FMAX; end
                0: begin vt = VMID; ft = FMID; end
                3: begin vt = VMID; ft = FMID - 1; end
                2: begin vt = 1; ft = 1; end
                default: begin vt = 0; ft = 0; end
            endcase
            if ((m_mode == 0 || m_mode == 3) && !dom_busy[d]) begin vt = 1; ft = 1; end
            if (ms[d] > 0) ms[d]--;
            else if (mf[d] > ft) begin mf[d]--; ms[d] = SETTLE; end
            else if (mv[d] != vt) begin mv[d] += (mv[d] < vt) ? 1 : -1; ms[d] = SETTLE; end
            else if (mf[d] < ft) begin mf[d]++; ms[d] = SETTLE; end
            if (mv[d] != vt || mf[d] != ft || ms[d] != 0) any = 1;
        end
        m_tb = any;
        if (batt_level < 2) c = 4;
        else if (temp_level >= 2) c = 3;
        else if (perf_req) c = 1;
        else if (dom_busy == 0) c = 2;
        else c = 0;
        if ((c == 4 || c == 3) && rank(c) > rank(m_mode)) begin
            m_mode = c; m_dwell = 0; if (m_cnt < 255) m_cnt++;
        end else if (c == m_mode) begin
            m_dwell = 0;
        end else begin
            m_dwell = (c != m_prev) ? 1 : m_dwell + 1;
            if (m_dwell == DWELL) begin
                m_mode = c; m_dwell = 0; if (m_cnt < 255) m_cnt++;
            end
        end
        m_prev = c;
    endtask

    function automatic logic [31:0] mdl_vec();
        logic [5:0] v;
        logic [8:0] f;
        logic [7:0] cnt;
        logic ps;
        for (int d = 0; d < ND; d++) begin
            v[d*VW +: VW] = VW'(mv[d]);
            f[d*FW +: FW] = FW'(mf[d]);
        end
        ps = (m_mode == 2 || m_mode == 4);
`ifdef DPMU_TRANS_CNT_EN
        cnt = 8'(m_cnt);
`else
        cnt = 8'd0;
`endif
        return {4'd0, cnt, 3'(m_mode), ps, 1'(m_tb), v, f};
    endfunction

    function automatic logic [31:0] dut_vec();
        logic [7:0] cnt;
`ifdef DPMU_TRANS_CNT_EN
        cnt = trans_cnt;
`else
        cnt = 8'd0;
`endif
        return {4'd0, cnt, mode, power_save, transition_busy, vlevel, flevel};
    endfunction

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
        chk("model", dut_vec(), mdl_vec());
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Asserts reset between edges, checks the async clear, releases after two edges.
    task automatic async_reset(input string tag);
        #3 rst = 1'b1;
        #1;
        chk({tag, "_v"}, 32'(vlevel), 32'd0);
        chk({tag, "_f"}, 32'(flevel), 32'd0);
        chk({tag, "_misc"}, {29'd0, mode} | {30'd0, power_save, transition_busy}, 32'd0);
`ifdef DPMU_TRANS_CNT_EN
        chk({tag, "_cnt"}, 32'(trans_cnt), 32'd0);
`endif
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
        model_reset();
    endtask

    task automatic set_in(input logic p, input logic [1:0] t, input logic [1:0] b, input logic [2:0] bz);
        perf_req = p; temp_level = t; batt_level = b; dom_busy = bz;
    endtask

    typedef struct {
        logic       perf;
        logic [1:0] temp;
        logic [1:0] batt;
        logic [2:0] busy;
        int         ncyc;
        logic [2:0] emode;
        logic [5:0] ev;
        logic [8:0] ef;
        logic       eps;
        logic       etb;
    } vec_t;

    vec_t tbl[10];

    initial begin
        #5_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int fseen;
        tbl[0] = '{1'b0, 2'd0, 2'd3, 3'b111, 40, 3'd0, 6'h2A, 9'h124, 1'b0, 1'b0};
        tbl[1] = '{1'b1, 2'd0, 2'd3, 3'b111, 60, 3'd1, 6'h3F, 9'h1FF, 1'b0, 1'b0};
        tbl[2] = '{1'b0, 2'd0, 2'd3, 3'b111, 60, 3'd0, 6'h2A, 9'h124, 1'b0, 1'b0};
        tbl[3] = '{1'b0, 2'd2, 2'd3, 3'b111, 30, 3'd3, 6'h2A, 9'h0DB, 1'b0, 1'b0};
        tbl[4] = '{1'b0, 2'd0, 2'd3, 3'b111, 40, 3'd0, 6'h2A, 9'h124, 1'b0, 1'b0};
        tbl[5] = '{1'b0, 2'd0, 2'd3, 3'b101, 60, 3'd0, 6'h26, 9'h10C, 1'b0, 1'b0};
        tbl[6] = '{1'b0, 2'd0, 2'd3, 3'b000, 60, 3'd2, 6'h15, 9'h049, 1'b1, 1'b0};
        tbl[7] = '{1'b0, 2'd0, 2'd1, 3'b111, 40, 3'd4, 6'h00, 9'h000, 1'b1, 1'b0};
        tbl[8] = '{1'b0, 2'd0, 2'd3, 3'b111, 80, 3'd0, 6'h2A, 9'h124, 1'b0, 1'b0};
        tbl[9] = '{1'b1, 2'd3, 2'd3, 3'b000, 40, 3'd3, 6'h15, 9'h049, 1'b0, 1'b0};

        // Reset state
        #1;
        chk("rst_v", 32'(vlevel), 32'd0);
        chk("rst_f", 32'(flevel), 32'd0);
        chk("rst_mode", 32'(mode), 32'd0);
        chk("rst_ps_tb", {30'd0, power_save, transition_busy}, 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
        model_reset();

        // Power-up ramp: steps at edges 1,6,11,16,21,26; idle from edge 30
        for (int e = 1; e <= 31; e++) begin
            tick();
            if (e == 1)  chk("ramp_e1_v", 32'(vlevel[1:0]), 32'd1);
            if (e == 5)  chk("ramp_e5_vf", {vlevel[1:0], 1'b0, flevel[2:0]}, {2'd1, 1'b0, 3'd0});
            if (e == 6)  chk("ramp_e6_v", 32'(vlevel[1:0]), 32'd2);
            if (e == 11) chk("ramp_e11_f", 32'(flevel[2:0]), 32'd1);
            if (e == 26) chk("ramp_e26_f", 32'(flevel[2:0]), 32'd4);
            if (e == 29) chk("ramp_e29_tb", 32'(transition_busy), 32'd1);
            if (e == 30) chk("ramp_e30_tb", 32'(transition_busy), 32'd0);
        end
        $display("ramp: mode=%0d v=%h f=%h tb=%0d", mode, vlevel, flevel, transition_busy);

        // Table of settled-state scenarios
        for (int r = 0; r < 10; r++) begin
            set_in(tbl[r].perf, tbl[r].temp, tbl[r].batt, tbl[r].busy);
            ticks(tbl[r].ncyc);
            chk($sformatf("row%0d_mode", r), 32'(mode), 32'(tbl[r].emode));
            chk($sformatf("row%0d_v", r), 32'(vlevel), 32'(tbl[r].ev));
            chk($sformatf("row%0d_f", r), 32'(flevel), 32'(tbl[r].ef));
            chk($sformatf("row%0d_ps_tb", r), {30'd0, power_save, transition_busy},
                {30'd0, tbl[r].eps, tbl[r].etb});
            $display("row %0d: mode=%0d v=%h f=%h ps=%0d tb=%0d", r, mode, vlevel, flevel,
                     power_save, transition_busy);
        end

        // Short PERF pulse is filtered by the dwell counter
        set_in(1'b0, 2'd0, 2'd3, 3'b111);
        ticks(60);
        set_in(1'b1, 2'd0, 2'd3, 3'b111);
        ticks(5);
        set_in(1'b0, 2'd0, 2'd3, 3'b111);
        ticks(4);
        chk("pulse_mode", 32'(mode), 32'd0);
        chk("pulse_vf", {vlevel, flevel, transition_busy}, {6'h2A, 9'h124, 1'b0});
        $display("perf pulse: mode=%0d v=%h f=%h", mode, vlevel, flevel);

        // Thermal entry is immediate, exit waits the dwell
        set_in(1'b0, 2'd2, 2'd3, 3'b111);
        tick();
        chk("therm_entry", 32'(mode), 32'd3);
        ticks(20);
        set_in(1'b0, 2'd0, 2'd3, 3'b111);
        ticks(7);
        chk("therm_exit_e7", 32'(mode), 32'd3);
        tick();
        chk("therm_exit_e8", 32'(mode), 32'd0);
        ticks(20);
        $display("thermal: mode=%0d f=%h", mode, flevel);

        // Battery emergency during PERF ramp: frequency must reach 0 before voltage drops
        set_in(1'b1, 2'd0, 2'd3, 3'b111);
        for (int i = 0; i < 100 && flevel[2:0] != 3'd5; i++) tick();
        chk("perf_reach_f5", {vlevel[1:0], 1'b0, flevel[2:0]}, {2'd3, 1'b0, 3'd5});
        set_in(1'b1, 2'd0, 2'd1, 3'b111);
        tick();
        chk("batt_entry", {mode, power_save}, {3'd4, 1'b1});
        fseen = -1;
        for (int i = 0; i < 100 && vlevel[1:0] != 2'd0; i++) begin
            tick();
            if (vlevel[1:0] != 2'd3 && fseen < 0) fseen = int'(flevel[2:0]);
        end
        chk("batt_f_before_v", 32'(fseen), 32'd0);
        ticks(6);
        chk("batt_done", {vlevel, flevel, transition_busy}, 16'd0);
        $display("battery: mode=%0d v=%h f=%h tb=%0d", mode, vlevel, flevel, transition_busy);

        // Reset mid-ramp
        set_in(1'b0, 2'd0, 2'd3, 3'b111);
        ticks(50);
        set_in(1'b1, 2'd0, 2'd3, 3'b111);
        ticks(14);
        async_reset("midramp");
        $display("mid-ramp reset: v=%h f=%h", vlevel, flevel);

        // Random stimulus against the model
        for (int s = 0; s < 200; s++) begin
            logic [1:0] b;
            b = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(0, 1)) : 2'($urandom_range(2, 3));
            set_in(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), b, 3'($urandom_range(0, 7)));
            ticks($urandom_range(1, 25));
            $display("rand %0d: in p=%0d t=%0d b=%0d busy=%b -> mode=%0d v=%h f=%h tb=%0d",
                     s, perf_req, temp_level, batt_level, dom_busy, mode, vlevel, flevel,
                     transition_busy);
            if ($urandom_range(0, 39) == 0) async_reset("rand_rst");
        end

`ifdef DPMU_TRANS_CNT_EN
        set_in(1'b0, 2'd0, 2'd3, 3'b111);
        ticks(10);
        for (int i = 0; i < 150; i++) begin
            temp_level = 2'd2;
            ticks(2);
            temp_level = 2'd0;
            ticks(9);
        end
        chk("cnt_saturate", 32'(trans_cnt), 32'd255);
        $display("trans_cnt after 300 changes: %0d", trans_cnt);
        async_reset("cnt_rst");
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule
